writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
- Writeback-side driver for the 32x32 register file's single write port (writeRegister/writeData/regWrite, sampled on posedge clk).
- Merges two result producers into that one port:
  - single-cycle ALU results;
  - multi-cycle memory-load results, buffered in a small FIFO.
- Exposes pending-write flags so decode can stall on read-after-write hazards.
- Sits between execute/memory stages and the register file.

Parameters:
DEPTH, 4, memory-result FIFO entries (power of 2, 2..16)
STARVE_LIMIT, 3, consecutive ALU-priority cycles with FIFO non-empty before memory is forced

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
aluValid  input  1  ALU result present this cycle
aluReady  output  1  ALU result accepted this cycle
aluReg  input  5  ALU destination register
aluData  input  32  ALU result
memValid  input  1  load result offered
memReady  output  1  FIFO can accept (valid&ready = transfer)
memReg  input  5  load destination register
memData  input  32  load data
queryReg1  input  5  decode source register 1
queryReg2  input  5  decode source register 2
pending1  output  1  queryReg1 has an unretired write in this block
pending2  output  1  queryReg2 has an unretired write in this block
regWrite  output  1  register file write enable (registered)
writeRegister  output  5  register file write address (registered)
writeData  output  32  register file write data (registered)

Behaviour:
- Reset, asynchronous on rst_n low:
  - regWrite=0, writeRegister=0, writeData=0.
  - FIFO empty; starve counter=0.
  - Consequently memReady=1, aluReady=1, pending1/2=0.
- memReady = (FIFO count < DEPTH); combinational. A push occurs when memValid&memReady.
- Per-cycle selection, registered to the outputs with 1-cycle latency:
  - forceMem = (starveCnt == STARVE_LIMIT) and FIFO non-empty.
  - aluReady = !forceMem.
  - If aluValid&aluReady: the ALU result drives the output stage next edge.
  - Else if FIFO non-empty: pop the head to the output stage.
  - Else: regWrite=0 next edge; writeRegister/writeData hold.
- Starve counter:
  - Increments when the ALU wins while the FIFO is non-empty.
  - Clears on any pop, and whenever the FIFO is empty.
  - Saturates at STARVE_LIMIT.
- Register 0:
  - Any result with destination 0 completes its handshake but is discarded.
  - ALU: no regWrite.
  - Memory: not pushed; count unchanged.
- Ordering:
  - An accepted ALU result is newer than every FIFO entry.
  - On acceptance, any FIFO entries with reg==aluReg are killed: marked invalid and popped without a write when they reach the head. A killed head still consumes a pop cycle with regWrite=0.
  - A memory push in the same cycle with memReg==aluReg is treated as older and is stored already killed.
- Simultaneous push and pop when full: pop happens this edge, but memReady is computed from the pre-edge count, so a full FIFO rejects the push in that cycle.
- pendingN is combinational. It is 1 if either:
  - any valid (non-killed) FIFO entry targets queryRegN; or
  - the output stage holds regWrite=1 with writeRegister==queryRegN.
- pendingN is always 0 for register 0.
- Counters and pointers wrap modulo DEPTH; count ranges 0..DEPTH.
- Reset mid-operation: all FIFO contents are dropped, and any in-flight write is cancelled immediately (regWrite low asynchronously).

Test Plan:
1. ALU-only path: aluValid with aluReg=5, aluData=0xDEADBEEF for one cycle -> next edge regWrite=1, writeRegister=5, writeData=0xDEADBEEF; following cycle regWrite=0.
2. Load buffering and full: push 4 loads (regs 1..4, data 0x11..0x44) while aluValid is held high with regs 10.. -> memReady=0 after the 4th push. After 3 ALU wins, aluReady=0 for one cycle and reg 1 / data 0x11 is written. Loads drain in order 1,2,3,4, interleaved with the starvation rule.
3. Kill on newer ALU write: FIFO holds reg 7 = 0x70, then an ALU write to reg 7 = 0x99 -> only reg 7 = 0x99 is written. The reg 7 pop cycle shows regWrite=0, and pending1 for reg 7 drops after the ALU write retires.
4. Register 0: ALU write to reg 0 plus a load to reg 0 -> no regWrite asserted, FIFO count unchanged, memReady stays 1, pending1=0 for query 0.
5. Pending flags: load to reg 12 accepted -> pending1=1 with queryReg1=12 until the cycle after writeRegister=12 retires; queryReg2=13 stays 0 throughout.
6. Async reset mid-drain: with 3 entries queued and regWrite=1, pull rst_n low between edges -> regWrite=0, writeRegister=0, writeData=0, pending=0 immediately. After release, memReady=1 and no stale writes occur.

Source files
------------

// File: rtl/writeback_arbiter.sv
// Writeback arbiter: merges single-cycle ALU results and FIFO-buffered load results
// onto the register file's single write port, with hazard-pending flags for decode.
module writeback_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        aluValid,
    output logic        aluReady,
    input  logic [4:0]  aluReg,
    input  logic [31:0] aluData,
    input  logic        memValid,
    output logic        memReady,
    input  logic [4:0]  memReg,
    input  logic [31:0] memData,
    input  logic [4:0]  queryReg1,
    input  logic [4:0]  queryReg2,
    output logic        pending1,
    output logic        pending2,
    output logic        regWrite,
    output logic [4:0]  writeRegister,
    output logic [31:0] writeData
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

    logic [4:0]       ent_reg_q  [DEPTH];
    logic [4:0]       ent_reg_d  [DEPTH];
    logic [31:0]      ent_data_q [DEPTH];
    logic [31:0]      ent_data_d [DEPTH];
    logic [DEPTH-1:0] ent_live_q, ent_live_d;
    logic [PW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [SW-1:0]    starve_q, starve_d;
    logic             reg_write_q, reg_write_d;
    logic [4:0]       write_reg_q, write_reg_d;
    logic [31:0]      write_data_q, write_data_d;

    logic             fifo_nonempty, force_mem, alu_acc, pop, push, push_live;
    logic [DEPTH-1:0] alu_match, hit1, hit2;

    assign fifo_nonempty = (count_q != '0);
    assign force_mem     = (starve_q == LIMIT_C) && fifo_nonempty;
    assign aluReady      = !force_mem;
    assign memReady      = (count_q < DEPTH_C);
    assign alu_acc       = aluValid && !force_mem;
    assign pop           = !alu_acc && fifo_nonempty;
    assign push          = memValid && memReady && (memReg != 5'd0);
    // A same-cycle load to the ALU's register is older, so it lands already killed.
    assign push_live     = !(alu_acc && (aluReg == memReg));

    assign regWrite      = reg_write_q;
    assign writeRegister = write_reg_q;
    assign writeData     = write_data_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign alu_match[gi] = (ent_reg_q[gi] == aluReg);
            assign hit1[gi]      = ent_live_q[gi] && (ent_reg_q[gi] == queryReg1);
            assign hit2[gi]      = ent_live_q[gi] && (ent_reg_q[gi] == queryReg2);
        end
    endgenerate

    always_comb begin
        pending1 = 1'b0;
        pending2 = 1'b0;
        if (queryReg1 != 5'd0) begin
            pending1 = (|hit1) || (reg_write_q && (write_reg_q == queryReg1));
        end
        if (queryReg2 != 5'd0) begin
            pending2 = (|hit2) || (reg_write_q && (write_reg_q == queryReg2));
        end
    end

    always_comb begin
        ent_reg_d    = ent_reg_q;
        ent_data_d   = ent_data_q;
        ent_live_d   = ent_live_q;
        head_d       = head_q;
        tail_d       = tail_q;
        count_d      = count_q;
        starve_d     = starve_q;
        reg_write_d  = 1'b0;
        write_reg_d  = write_reg_q;
        write_data_d = write_data_q;

        if (alu_acc) begin
            if (aluReg != 5'd0) begin
                reg_write_d  = 1'b1;
                write_reg_d  = aluReg;
                write_data_d = aluData;
                ent_live_d   = ent_live_q & ~alu_match;
            end
        end else if (pop) begin
            // Killed heads still burn this slot, just without a write.
            if (ent_live_q[head_q]) begin
                reg_write_d  = 1'b1;
                write_reg_d  = ent_reg_q[head_q];
                write_data_d = ent_data_q[head_q];
            end
            ent_live_d[head_q] = 1'b0;
            head_d             = head_q + PW'(1);
        end

        if (push) begin
            ent_reg_d[tail_q]  = memReg;
            ent_data_d[tail_q] = memData;
            ent_live_d[tail_q] = push_live;
            tail_d             = tail_q + PW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        if (pop || !fifo_nonempty) begin
            starve_d = '0;
        end else if (alu_acc && (starve_q != LIMIT_C)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_reg_q[i]  <= '0;
                ent_data_q[i] <= '0;
            end
            ent_live_q   <= '0;
            head_q       <= '0;
            tail_q       <= '0;
            count_q      <= '0;
            starve_q     <= '0;
            reg_write_q  <= 1'b0;
            write_reg_q  <= '0;
            write_data_q <= '0;
        end else begin
            ent_reg_q    <= ent_reg_d;
            ent_data_q   <= ent_data_d;
            ent_live_q   <= ent_live_d;
            head_q       <= head_d;
            tail_q       <= tail_d;
            count_q      <= count_d;
            starve_q     <= starve_d;
            reg_write_q  <= reg_write_d;
            write_reg_q  <= write_reg_d;
            write_data_q <= write_data_d;
        end
    end
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based reference model of the arbitration rules.
module tb_writeback_arbiter;
    localparam int DEPTH = 4;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        aluValid, aluReady, memValid, memReady;
    logic [4:0]  aluReg, memReg, queryReg1, queryReg2, writeRegister;
    logic [31:0] aluData, memData, writeData;
    logic        pending1, pending2, regWrite;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    int          m_starve;
    bit          m_we;
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    always #5 clk = ~clk;

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .aluValid(aluValid), .aluReady(aluReady), .aluReg(aluReg), .aluData(aluData),
        .memValid(memValid), .memReady(memReady), .memReg(memReg), .memData(memData),
        .queryReg1(queryReg1), .queryReg2(queryReg2),
        .pending1(pending1), .pending2(pending2),
        .regWrite(regWrite), .writeRegister(writeRegister), .writeData(writeData)
    );

    task automatic idle();
        aluValid = 1'b0; aluReg = '0; aluData = '0;
        memValid = 1'b0; memReg = '0; memData = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        idle();
        queryReg1 = '0; queryReg2 = '0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // Reference model: queue of entries, advanced once per clock from current inputs.
    function automatic bit m_pending(input logic [4:0] q);
        if (q == 5'd0) return 1'b0;
        if (m_we && m_reg == q) return 1'b1;
        foreach (mq[i]) if (mq[i].live && mq[i].r == q) return 1'b1;
        return 1'b0;
    endfunction

    task automatic m_advance();
        bit acc, popped;
        ent_t e;
        int pre;
        pre = mq.size();
        acc = aluValid && !(m_starve == LIMIT && pre > 0);
        popped = !acc && pre > 0;
        if (acc) begin
            m_we = (aluReg != 5'd0);
            if (aluReg != 5'd0) begin m_reg = aluReg; m_data = aluData; end
        end else if (popped) begin
            e = mq.pop_front();
            m_we = e.live;
            if (e.live) begin m_reg = e.r; m_data = e.d; end
        end else begin
            m_we = 1'b0;
        end
        if (popped || pre == 0) m_starve = 0;
        else if (acc && m_starve < LIMIT) m_starve++;
        if (acc && aluReg != 5'd0)
            foreach (mq[i]) if (mq[i].r == aluReg) mq[i].live = 1'b0;
        if (memValid && pre < DEPTH && memReg != 5'd0) begin
            e.r = memReg; e.d = memData; e.live = !(acc && aluReg == memReg);
            mq.push_back(e);
        end
    endtask

    task automatic test_reset();
        idle();
        queryReg1 = 5'd3; queryReg2 = 5'd4;
        step();
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({regWrite, writeRegister, writeData} !== {1'b0, 5'd0, 32'd0}) begin
            n_fail++; $display("FAIL reset_out got=%h exp=%h", {regWrite, writeRegister, writeData}, 38'd0);
        end
        n_tests++;
        if ({memReady, aluReady, pending1, pending2} !== 4'b1100) begin
            n_fail++; $display("FAIL reset_flags got=%b exp=1100", {memReady, aluReady, pending1, pending2});
        end
        step();
        rst_n = 1'b1;
        step();
        $display("[TB] test_reset done");
    endtask

    task automatic test_alu_only();
        apply_reset();
        aluValid = 1'b1; aluReg = 5'd5; aluData = 32'hDEADBEEF;
        #1;
        n_tests++;
        if (aluReady !== 1'b1) begin n_fail++; $display("FAIL alu_ready got=%b exp=1", aluReady); end
        step();
        idle();
        n_tests++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL alu_write got=%b/%0d/%h exp=1/5/deadbeef", regWrite, writeRegister, writeData);
        end
        step();
        n_tests++;
        if ({regWrite, writeRegister, writeData} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL alu_hold got=%b/%0d/%h exp=0/5/deadbeef", regWrite, writeRegister, writeData);
        end
        $display("[TB] test_alu_only: r5 <= deadbeef");
    endtask

    task automatic test_load_full();
        int got_r[$];
        int got_d[$];
        int forced;
        apply_reset();
        for (int k = 0; k < 4; k++) begin
            memValid = 1'b1; memReg = 5'(k + 1); memData = 32'(8'h11 * (k + 1));
            aluValid = 1'b1; aluReg = 5'(10 + k); aluData = 32'(16'h1000 + k);
            #1;
            n_tests++;
            if ({memReady, aluReady} !== 2'b11) begin
                n_fail++; $display("FAIL fill_ready k=%0d got=%b exp=11", k, {memReady, aluReady});
            end
            step();
            n_tests++;
            if ({regWrite, writeRegister} !== {1'b1, 5'(10 + k)}) begin
                n_fail++; $display("FAIL fill_alu k=%0d got=%b/%0d exp=1/%0d", k, regWrite, writeRegister, 10 + k);
            end
        end
        memValid = 1'b0;
        aluReg = 5'd14;
        #1;
        n_tests++;
        if ({memReady, aluReady} !== 2'b00) begin
            n_fail++; $display("FAIL full_ready got=%b exp=00", {memReady, aluReady});
        end
        step();
        n_tests++;
        if ({regWrite, writeRegister, writeData} !== {1'b1, 5'd1, 32'h11}) begin
            n_fail++; $display("FAIL forced_pop got=%b/%0d/%h exp=1/1/11", regWrite, writeRegister, writeData);
        end
        forced = 0;
        for (int i = 0; i < 24; i++) begin
            aluReg = 5'(14 + (i % 16)); aluData = 32'(i);
            #1;
            if (!aluReady) forced++;
            step();
            if (regWrite && writeRegister < 5'd10) begin
                got_r.push_back(int'(writeRegister));
                got_d.push_back(int'(writeData));
            end
        end
        idle();
        n_tests++;
        if (forced !== 3) begin n_fail++; $display("FAIL drain_forced got=%0d exp=3", forced); end
        n_tests++;
        if (got_r.size() !== 3) begin
            n_fail++; $display("FAIL drain_count got=%0d exp=3", got_r.size());
        end else begin
            for (int j = 0; j < 3; j++) begin
                n_tests++;
                if (got_r[j] !== j + 2 || got_d[j] !== 8'h11 * (j + 2)) begin
                    n_fail++; $display("FAIL drain_order j=%0d got=%0d/%h exp=%0d/%h", j, got_r[j], got_d[j], j + 2, 8'h11 * (j + 2));
                end
            end
        end
        $display("[TB] test_load_full: drained %0d loads", got_r.size() + 1);
    endtask

    task automatic test_kill();
        apply_reset();
        queryReg1 = 5'd7;
        memValid = 1'b1; memReg = 5'd7; memData = 32'h70;
        aluValid = 1'b1; aluReg = 5'd20; aluData = 32'h20;
        step();
        memValid = 1'b0;
        aluReg = 5'd7; aluData = 32'h99;
        #1;
        n_tests++;
        if ({pending1, aluReady} !== 2'b11) begin
            n_fail++; $display("FAIL kill_pre got=%b exp=11", {pending1, aluReady});
        end
        step();
        idle();
        #1;
        n_tests++;
        if ({regWrite, writeRegister, writeData, pending1} !== {1'b1, 5'd7, 32'h99, 1'b1}) begin
            n_fail++; $display("FAIL kill_alu got=%b/%0d/%h p=%b exp=1/7/99 p=1", regWrite, writeRegister, writeData, pending1);
        end
        step();
        #1;
        n_tests++;
        if ({regWrite, writeData, pending1} !== {1'b0, 32'h99, 1'b0}) begin
            n_fail++; $display("FAIL kill_pop got=%b/%h p=%b exp=0/99 p=0", regWrite, writeData, pending1);
        end
        step();
        n_tests++;
        if ({regWrite, memReady} !== 2'b01) begin
            n_fail++; $display("FAIL kill_after got=%b exp=01", {regWrite, memReady});
        end
        $display("[TB] test_kill: r7 <= 99, stale load dropped");
    endtask

    task automatic test_reg0();
        int bad;
        apply_reset();
        queryReg1 = 5'd0;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            aluValid = 1'b1; aluReg = 5'd0; aluData = 32'(i);
            memValid = 1'b1; memReg = 5'd0; memData = 32'(i + 100);
            #1;
            if ({memReady, aluReady, pending1} !== 3'b110) bad++;
            step();
            if (regWrite !== 1'b0) bad++;
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            step();
            if (regWrite !== 1'b0 || memReady !== 1'b1) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL reg0 got=%0d bad cycles exp=0", bad); end
        $display("[TB] test_reg0: writes to r0 discarded");
    endtask

    task automatic test_pending();
        logic exp_p1 [6];
        exp_p1 = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        apply_reset();
        queryReg1 = 5'd12; queryReg2 = 5'd13;
        for (int t = 0; t < 6; t++) begin
            idle();
            if (t == 0) begin memValid = 1'b1; memReg = 5'd12; memData = 32'hC0; end
            if (t < 3) begin aluValid = 1'b1; aluReg = 5'(20 + t); aluData = 32'(t); end
            #1;
            n_tests++;
            if ({pending1, pending2} !== {exp_p1[t], 1'b0}) begin
                n_fail++; $display("FAIL pending t=%0d got=%b%b exp=%b0", t, pending1, pending2, exp_p1[t]);
            end
            if (t == 4) begin
                n_tests++;
                if ({regWrite, writeRegister, writeData} !== {1'b1, 5'd12, 32'hC0}) begin
                    n_fail++; $display("FAIL pending_write got=%b/%0d/%h exp=1/12/c0", regWrite, writeRegister, writeData);
                end
            end
            step();
        end
        $display("[TB] test_pending: r12 <= c0");
    endtask

    task automatic test_async_reset();
        int bad;
        apply_reset();
        queryReg1 = 5'd2; queryReg2 = 5'd1;
        for (int k = 0; k < 5; k++) begin
            idle();
            if (k < 4) begin memValid = 1'b1; memReg = 5'(k + 1); memData = 32'(8'h11 * (k + 1)); end
            aluValid = 1'b1; aluReg = 5'(10 + k); aluData = 32'(k);
            step();
        end
        idle();
        n_tests++;
        if ({regWrite, writeRegister, pending1} !== {1'b1, 5'd1, 1'b1}) begin
            n_fail++; $display("FAIL arst_pre got=%b/%0d p=%b exp=1/1 p=1", regWrite, writeRegister, pending1);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({regWrite, writeRegister, writeData, pending1, pending2} !== 39'd0) begin
            n_fail++; $display("FAIL arst_now got=%b/%0d/%h p=%b%b exp=0/0/0 p=00", regWrite, writeRegister, writeData, pending1, pending2);
        end
        step();
        rst_n = 1'b1;
        #1;
        n_tests++;
        if ({memReady, aluReady} !== 2'b11) begin
            n_fail++; $display("FAIL arst_ready got=%b exp=11", {memReady, aluReady});
        end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (regWrite !== 1'b0 || pending1 !== 1'b0) bad++;
        end
        n_tests++;
        if (bad !== 0) begin n_fail++; $display("FAIL arst_stale got=%0d bad cycles exp=0", bad); end
        $display("[TB] test_async_reset: queue dropped");
    endtask

    task automatic test_random();
        int writes;
        apply_reset();
        mq.delete();
        m_starve = 0; m_we = 1'b0; m_reg = '0; m_data = '0;
        writes = 0;
        for (int c = 0; c < 400; c++) begin
            aluValid  = ($urandom_range(0, 9) < 6);
            aluReg    = 5'($urandom_range(0, 7));
            aluData   = $urandom();
            memValid  = ($urandom_range(0, 9) < 6);
            memReg    = 5'($urandom_range(0, 7));
            memData   = $urandom();
            queryReg1 = 5'($urandom_range(0, 7));
            queryReg2 = 5'($urandom_range(0, 7));
            #1;
            n_tests++;
            if ({memReady, aluReady} !== {mq.size() < DEPTH, !(m_starve == LIMIT && mq.size() > 0)}) begin
                n_fail++; $display("FAIL rnd_ready c=%0d got=%b%b exp=%b%b", c, memReady, aluReady,
                                   mq.size() < DEPTH, !(m_starve == LIMIT && mq.size() > 0));
            end
            n_tests++;
            if ({pending1, pending2} !== {m_pending(queryReg1), m_pending(queryReg2)}) begin
                n_fail++; $display("FAIL rnd_pending c=%0d q=%0d,%0d got=%b%b exp=%b%b", c, queryReg1, queryReg2,
                                   pending1, pending2, m_pending(queryReg1), m_pending(queryReg2));
            end
            n_tests++;
            if ({regWrite, writeRegister, writeData} !== {m_we, m_reg, m_data}) begin
                n_fail++; $display("FAIL rnd_out c=%0d got=%b/%0d/%h exp=%b/%0d/%h", c, regWrite, writeRegister,
                                   writeData, m_we, m_reg, m_data);
            end
            if (m_we) writes++;
            m_advance();
            step();
        end
        idle();
        $display("[TB] test_random: 400 cycles, %0d writes", writes);
    endtask

    initial begin
        idle();
        queryReg1 = '0; queryReg2 = '0;
        test_reset();
        test_alu_only();
        test_load_full();
        test_kill();
        test_reg0();
        test_pending();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
